// File: rtl/menu_list_ui_if.sv
// Character-write handshake between a UI page and the shared LCD writer.
// The page (master) issues one-cycle requests; the writer answers busy/done.
interface menu_list_ui_if;
    logic       lcd_req;
    logic [1:0] lcd_row;
    logic [4:0] lcd_col;
    logic [7:0] lcd_char;
    logic       lcd_busy;
    logic       lcd_done;

    modport master (
        output lcd_req,
        output lcd_row,
        output lcd_col,
        output lcd_char,
        input  lcd_busy,
        input  lcd_done
    );

    modport slave (
        input  lcd_req,
        input  lcd_row,
        input  lcd_col,
        input  lcd_char,
        output lcd_busy,
        output lcd_done
    );
endinterface

// File: rtl/menu_list_ui.sv
// Scrolling menu page: keypad cursor control, UI-change requests and
// full-window LCD redraw with scroll indicators and coalesced refresh.
module menu_list_ui #(
    parameter int                            MENU_COUNT     = 6,
    parameter int                            STR_LEN        = 12,
    parameter int                            LCD_ROWS       = 2,
    parameter int                            LCD_COLS       = 16,
    parameter bit                            WRAP           = 1'b1,
    parameter logic [MENU_COUNT*STR_LEN*8-1:0] MENU_STR_FLAT = '0,
    parameter logic [MENU_COUNT*4-1:0]       NEXT_UUID_FLAT = '0,
    parameter logic [3:0]                    BACK_UUID      = 4'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  is_active,
    input  logic [10:0]           key_packet,
    input  logic                  key_valid,
    menu_list_ui_if.master        lcd,
    output logic                  change_req,
    output logic [3:0]            next_ui_id,
    output logic [3:0]            cursor_idx
);

    localparam logic [10:0] KEY_UP    = 11'h004;
    localparam logic [10:0] KEY_DOWN  = 11'h008;
    localparam logic [10:0] KEY_ENTER = 11'h420;
    localparam logic [10:0] KEY_BACK  = 11'h410;

    localparam logic [3:0] LAST_ITEM = 4'(MENU_COUNT - 1);
    localparam logic [3:0] TOP_WRAP  =
        4'((MENU_COUNT > LCD_ROWS) ? (MENU_COUNT - LCD_ROWS) : 0);
    localparam logic [3:0] ROWS_M1   = 4'(LCD_ROWS - 1);
    localparam logic [1:0] LAST_ROW  = 2'(LCD_ROWS - 1);
    localparam logic [4:0] LAST_COL  = 5'(LCD_COLS - 1);
    localparam logic [4:0] LBL_END   = 5'(STR_LEN + 1);
    localparam logic [4:0] ROWS5     = 5'(LCD_ROWS);
    localparam logic [4:0] COUNT5    = 5'(MENU_COUNT);
    localparam logic [7:0] CH_SPACE  = 8'h20;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_NEXT
    } state_e;

    // Label and target-id lookup tables, padded to power-of-two depth so
    // they can be indexed straight from the cursor/column registers.
    logic [7:0] label_tab [16][32];
    logic [3:0] uuid_tab  [16];

    for (genvar gi = 0; gi < 16; gi++) begin : g_item
        if (gi < MENU_COUNT) begin : g_uuid_used
            assign uuid_tab[gi] = NEXT_UUID_FLAT[(MENU_COUNT-1-gi)*4 +: 4];
        end else begin : g_uuid_pad
            assign uuid_tab[gi] = 4'h0;
        end
        for (genvar gc = 0; gc < 32; gc++) begin : g_chr
            if (gi < MENU_COUNT && gc < STR_LEN) begin : g_used
                assign label_tab[gi][gc] =
                    MENU_STR_FLAT[((MENU_COUNT-1-gi)*STR_LEN
                                   + (STR_LEN-1-gc))*8 +: 8];
            end else begin : g_pad
                assign label_tab[gi][gc] = CH_SPACE;
            end
        end
    end

    state_e     state_q, state_d;
    logic [3:0] cursor_q, cursor_d;
    logic [3:0] top_q, top_d;
    logic       dirty_q, dirty_d;
    logic       active_q, active_d;
    logic [1:0] row_q, row_d;
    logic [4:0] col_q, col_d;
    logic       lcd_req_q, lcd_req_d;
    logic [7:0] lcd_char_q, lcd_char_d;
    logic       change_req_q, change_req_d;
    logic [3:0] next_id_q, next_id_d;

    logic       key_ok;
    logic       k_up;
    logic       k_down;
    logic       k_enter;
    logic       k_back;
    logic       activate;
    logic       running;

    assign key_ok   = is_active && key_valid;
    assign k_up     = key_ok && (key_packet == KEY_UP);
    assign k_down   = key_ok && (key_packet == KEY_DOWN);
    assign k_enter  = key_ok && (key_packet == KEY_ENTER);
    assign k_back   = key_ok && (key_packet == KEY_BACK);
    assign activate = is_active && !active_q;
    assign running  = is_active && active_q;

    logic [4:0] item;
    logic [4:0] lbl_idx;
    logic       show_up;
    logic       show_down;
    logic [7:0] cell_char;

    // Character for the cell at (row_q, col_q) given the current view.
    always_comb begin
        item      = {1'b0, top_q} + {3'b000, row_q};
        lbl_idx   = col_q - 5'd2;
        show_up   = (row_q == 2'd0) && (top_q != 4'd0);
        show_down = (row_q == LAST_ROW)
                    && (({1'b0, top_q} + ROWS5) < COUNT5);
        cell_char = CH_SPACE;
        if (col_q == LAST_COL) begin
            if (show_down) begin
                cell_char = 8'h76;
            end else if (show_up) begin
                cell_char = 8'h5E;
            end
        end else if (col_q == 5'd0) begin
            if (item == {1'b0, cursor_q}) begin
                cell_char = 8'h3E;
            end
        end else if (col_q >= 5'd2 && col_q <= LBL_END
                     && item < COUNT5) begin
            cell_char = label_tab[item[3:0]][lbl_idx];
        end
    end

    // Next state: render sequencer first, then key and activation updates
    // so a fresh change always re-arms dirty over the frame-start clear.
    always_comb begin
        state_d      = state_q;
        cursor_d     = cursor_q;
        top_d        = top_q;
        dirty_d      = dirty_q;
        active_d     = is_active;
        row_d        = row_q;
        col_d        = col_q;
        lcd_req_d    = 1'b0;
        lcd_char_d   = lcd_char_q;
        change_req_d = 1'b0;
        next_id_d    = next_id_q;

        if (!running) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (dirty_q && !lcd.lcd_busy) begin
                        dirty_d = 1'b0;
                        row_d   = 2'd0;
                        col_d   = 5'd0;
                        state_d = S_SEND;
                    end
                end
                S_SEND: begin
                    if (!lcd.lcd_busy) begin
                        lcd_req_d  = 1'b1;
                        lcd_char_d = cell_char;
                        state_d    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (lcd.lcd_done) begin
                        state_d = S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (col_q != LAST_COL) begin
                        col_d   = col_q + 5'd1;
                        state_d = S_SEND;
                    end else if (row_q != LAST_ROW) begin
                        row_d   = row_q + 2'd1;
                        col_d   = 5'd0;
                        state_d = S_SEND;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (activate) begin
            cursor_d = 4'd0;
            top_d    = 4'd0;
            dirty_d  = 1'b1;
        end else if (k_up) begin
            if (cursor_q != 4'd0) begin
                cursor_d = cursor_q - 4'd1;
                if (cursor_d < top_q) begin
                    top_d = cursor_d;
                end
                dirty_d = 1'b1;
            end else if (WRAP) begin
                cursor_d = LAST_ITEM;
                top_d    = TOP_WRAP;
                dirty_d  = 1'b1;
            end
        end else if (k_down) begin
            if (cursor_q != LAST_ITEM) begin
                cursor_d = cursor_q + 4'd1;
                if ({1'b0, cursor_d} > ({1'b0, top_q} + {1'b0, ROWS_M1})) begin
                    top_d = cursor_d - ROWS_M1;
                end
                dirty_d = 1'b1;
            end else if (WRAP) begin
                cursor_d = 4'd0;
                top_d    = 4'd0;
                dirty_d  = 1'b1;
            end
        end

        if (k_enter) begin
            change_req_d = 1'b1;
            next_id_d    = uuid_tab[cursor_q];
        end else if (k_back) begin
            change_req_d = 1'b1;
            next_id_d    = BACK_UUID;
        end
    end

    // State registers; reset leaves the page idle with a redraw pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cursor_q     <= 4'd0;
            top_q        <= 4'd0;
            dirty_q      <= 1'b1;
            active_q     <= 1'b0;
            row_q        <= 2'd0;
            col_q        <= 5'd0;
            lcd_req_q    <= 1'b0;
            lcd_char_q   <= 8'h00;
            change_req_q <= 1'b0;
            next_id_q    <= 4'h0;
        end else begin
            state_q      <= state_d;
            cursor_q     <= cursor_d;
            top_q        <= top_d;
            dirty_q      <= dirty_d;
            active_q     <= active_d;
            row_q        <= row_d;
            col_q        <= col_d;
            lcd_req_q    <= lcd_req_d;
            lcd_char_q   <= lcd_char_d;
            change_req_q <= change_req_d;
            next_id_q    <= next_id_d;
        end
    end

    assign lcd.lcd_req  = lcd_req_q;
    assign lcd.lcd_row  = row_q;
    assign lcd.lcd_col  = col_q;
    assign lcd.lcd_char = lcd_char_q;
    assign change_req   = change_req_q;
    assign next_ui_id   = next_id_q;
    assign cursor_idx   = cursor_q;

endmodule

// File: tb/tb_menu_list_ui.sv
// Testbench for menu_list_ui: scoreboard of expected LCD writes and
// UI-change pulses against a behavioural menu model, random keys included.
module tb_menu_list_ui;

    localparam int N  = 6;
    localparam int SL = 12;
    localparam int R  = 2;
    localparam int C  = 16;
    localparam logic [N*SL*8-1:0] LBL = {
        "Set Time    ", "Alarm       ", "Contrast    ",
        "Key Speed   ", "Morse Table ", "About       "};
    localparam logic [N*4-1:0] UUID    = 24'h123456;
    localparam logic [3:0]     BACK_ID = 4'hA;

    localparam logic [10:0] K_UP = 11'h004;
    localparam logic [10:0] K_DN = 11'h008;
    localparam logic [10:0] K_EN = 11'h420;
    localparam logic [10:0] K_BK = 11'h410;

    typedef struct {
        logic [1:0] row;
        logic [4:0] col;
        logic [7:0] ch;
        bit         wild;
    } exp_t;

    string labels [N] = '{"Set Time    ", "Alarm       ", "Contrast    ",
                          "Key Speed   ", "Morse Table ", "About       "};
    int    uuid_m [N] = '{1, 2, 3, 4, 5, 6};

    exp_t       exp_q [$];
    logic [3:0] chg_q [$];

    logic        clk;
    logic        rst;
    logic        is_active;
    logic [10:0] key_packet;
    logic        key_valid;
    logic        change_req;
    logic [3:0]  next_ui_id;
    logic [3:0]  cursor_idx;
    logic        nw_change_req;
    logic [3:0]  nw_next_ui_id;
    logic [3:0]  nw_cursor_idx;

    menu_list_ui_if lcd_if ();
    menu_list_ui_if nw_if ();

    menu_list_ui #(
        .MENU_COUNT(N), .STR_LEN(SL), .LCD_ROWS(R), .LCD_COLS(C),
        .WRAP(1'b1), .MENU_STR_FLAT(LBL), .NEXT_UUID_FLAT(UUID),
        .BACK_UUID(BACK_ID)
    ) u_dut (
        .clk(clk), .rst(rst), .is_active(is_active),
        .key_packet(key_packet), .key_valid(key_valid),
        .lcd(lcd_if.master),
        .change_req(change_req), .next_ui_id(next_ui_id),
        .cursor_idx(cursor_idx)
    );

    menu_list_ui #(
        .MENU_COUNT(N), .STR_LEN(SL), .LCD_ROWS(R), .LCD_COLS(C),
        .WRAP(1'b0), .MENU_STR_FLAT(LBL), .NEXT_UUID_FLAT(UUID),
        .BACK_UUID(BACK_ID)
    ) u_nowrap (
        .clk(clk), .rst(rst), .is_active(is_active),
        .key_packet(key_packet), .key_valid(key_valid),
        .lcd(nw_if.master),
        .change_req(nw_change_req), .next_ui_id(nw_next_ui_id),
        .cursor_idx(nw_cursor_idx)
    );

    int errors = 0;
    int checks = 0;
    int main_reqs = 0;
    int nw_reqs = 0;
    int quiet = 0;
    bit busy_rand = 0;

    int         m_cur;
    int         m_top;
    int         nw_cur;
    logic [3:0] m_id;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    function automatic logic [7:0] exp_char(input int r, input int c);
        int item;
        item = m_top + r;
        if (c == C - 1) begin
            if (r == R - 1 && m_top + R < N) return 8'h76;
            if (r == 0 && m_top > 0) return 8'h5E;
            return 8'h20;
        end
        if (c == 0) return (item == m_cur) ? 8'h3E : 8'h20;
        if (c >= 2 && c < 2 + SL && item < N) return labels[item][c-2];
        return 8'h20;
    endfunction

    task automatic push_frame(input bit wild);
        exp_t e;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                e.row  = 2'(r);
                e.col  = 5'(c);
                e.ch   = exp_char(r, c);
                e.wild = wild;
                exp_q.push_back(e);
            end
        end
    endtask

    // Menu semantics: cursor moves, view follows, wrap on the main page.
    task automatic model_key(input logic [10:0] pk, output bit redraw);
        redraw = 0;
        if (pk == K_UP) begin
            if (nw_cur > 0) nw_cur--;
            if (m_cur > 0) begin
                m_cur--;
                if (m_cur < m_top) m_top = m_cur;
            end else begin
                m_cur = N - 1;
                m_top = (N > R) ? N - R : 0;
            end
            redraw = 1;
        end else if (pk == K_DN) begin
            if (nw_cur < N - 1) nw_cur++;
            if (m_cur < N - 1) begin
                m_cur++;
                if (m_cur > m_top + R - 1) m_top = m_cur - R + 1;
            end else begin
                m_cur = 0;
                m_top = 0;
            end
            redraw = 1;
        end else if (pk == K_EN) begin
            m_id = 4'(uuid_m[m_cur]);
            chg_q.push_back(m_id);
        end else if (pk == K_BK) begin
            m_id = BACK_ID;
            chg_q.push_back(m_id);
        end
    endtask

    task automatic send_key(input logic [10:0] pk);
        @(posedge clk);
        #1;
        key_packet = pk;
        key_valid  = 1'b1;
        @(posedge clk);
        #1;
        key_valid  = 1'b0;
        key_packet = 11'h000;
    endtask

    task automatic wait_quiet();
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && chg_q.size() == 0 && quiet >= 8)
               && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check("quiet_timeout", int'(n < 3000), 1);
        #1;
    endtask

    task automatic key_step(input logic [10:0] pk);
        bit rd;
        model_key(pk, rd);
        if (rd) push_frame(0);
        send_key(pk);
        wait_quiet();
        check("cursor_idx", int'(cursor_idx), m_cur);
        check("nowrap_cursor", int'(nw_cursor_idx), nw_cur);
    endtask

    // LCD writers: done one cycle after each request, optional random busy.
    initial begin
        lcd_if.lcd_busy = 1'b0;
        lcd_if.lcd_done = 1'b0;
        nw_if.lcd_busy  = 1'b0;
        nw_if.lcd_done  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            lcd_if.lcd_done = lcd_if.lcd_req;
            lcd_if.lcd_busy = busy_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
            nw_if.lcd_done  = nw_if.lcd_req;
        end
    end

    // Monitor: pop and compare whenever the DUT presents an output.
    initial begin
        exp_t       e;
        logic [3:0] id;
        forever begin
            @(negedge clk);
            if (lcd_if.lcd_req || nw_if.lcd_req) quiet = 0;
            else quiet++;
            if (nw_if.lcd_req) nw_reqs++;
            if (lcd_if.lcd_req) begin
                main_reqs++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL lcd_unexpected: got r%0d c%0d ch %h, want none",
                             lcd_if.lcd_row, lcd_if.lcd_col, lcd_if.lcd_char);
                end else begin
                    e = exp_q.pop_front();
                    if (lcd_if.lcd_row != e.row || lcd_if.lcd_col != e.col
                        || (!e.wild && lcd_if.lcd_char != e.ch)) begin
                        errors++;
                        $display("FAIL lcd_write: got r%0d c%0d ch %h, want r%0d c%0d ch %h",
                                 lcd_if.lcd_row, lcd_if.lcd_col, lcd_if.lcd_char,
                                 e.row, e.col, e.ch);
                    end
                end
            end
            if (change_req) begin
                checks++;
                if (chg_q.size() == 0) begin
                    errors++;
                    $display("FAIL change_unexpected: got id %0h, want none",
                             next_ui_id);
                end else begin
                    id = chg_q.pop_front();
                    if (next_ui_id != id) begin
                        errors++;
                        $display("FAIL change_id: got %0h want %0h", next_ui_id, id);
                    end
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [10:0] pool [7] = '{K_UP, K_DN, K_EN, K_BK, 11'h001, 11'h404, 11'h108};

    initial begin
        int  r0;
        int  n;
        bit  rd;
        rst        = 1'b1;
        is_active  = 1'b0;
        key_packet = 11'h000;
        key_valid  = 1'b0;
        m_cur = 0; m_top = 0; nw_cur = 0; m_id = 4'h0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_lcd_req", int'(lcd_if.lcd_req), 0);
        check("rst_lcd_char", int'(lcd_if.lcd_char), 0);
        check("rst_change_req", int'(change_req), 0);
        check("rst_cursor", int'(cursor_idx), 0);
        rst       = 1'b0;
        is_active = 1'b1;
        r0 = main_reqs;
        push_frame(0);
        wait_quiet();
        check("first_frame_reqs", main_reqs - r0, 32);
        check("first_cursor", int'(cursor_idx), 0);

        key_step(K_DN);
        key_step(K_DN);
        key_step(K_UP);
        key_step(K_UP);
        r0 = nw_reqs;
        key_step(K_UP);
        check("nowrap_no_redraw", nw_reqs - r0, 0);
        key_step(K_DN);

        // three DOWNs inside one frame coalesce into a single extra frame
        r0 = main_reqs;
        model_key(K_DN, rd);
        push_frame(1);
        send_key(K_DN);
        repeat (10) @(posedge clk);
        model_key(K_DN, rd);
        send_key(K_DN);
        repeat (10) @(posedge clk);
        model_key(K_DN, rd);
        send_key(K_DN);
        push_frame(0);
        wait_quiet();
        check("coalesce_reqs", main_reqs - r0, 64);
        check("coalesce_cursor", int'(cursor_idx), m_cur);

        key_step(K_UP);
        key_step(K_EN);
        check("enter_id", int'(next_ui_id), int'(m_id));
        key_step(K_BK);
        check("back_id", int'(next_ui_id), int'(BACK_ID));

        busy_rand = 1;
        for (int i = 0; i < 25; i++) begin
            key_step(pool[$urandom_range(0, 6)]);
            check("rand_id_hold", int'(next_ui_id), int'(m_id));
        end
        busy_rand = 0;
        repeat (4) @(posedge clk);
        #1;

        // abort a frame by leaving the page, then re-enter
        model_key(K_DN, rd);
        push_frame(0);
        send_key(K_DN);
        r0 = main_reqs;
        n = 0;
        while (main_reqs < r0 + 5 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drop_wait_timeout", int'(n < 500), 1);
        is_active = 1'b0;
        @(posedge clk);
        #1;
        check("drop_req_low", int'(lcd_if.lcd_req), 0);
        exp_q.delete();
        send_key(K_DN);
        repeat (3) @(posedge clk);
        #1;
        check("inactive_cursor_held", int'(cursor_idx), m_cur);
        check("inactive_no_req", int'(lcd_if.lcd_req), 0);
        is_active = 1'b1;
        m_cur = 0; m_top = 0; nw_cur = 0;
        r0 = main_reqs;
        push_frame(0);
        wait_quiet();
        check("reentry_cursor", int'(cursor_idx), 0);
        check("reentry_reqs", main_reqs - r0, 32);

        // reset while the page waits for lcd_done
        model_key(K_UP, rd);
        push_frame(0);
        send_key(K_UP);
        n = 0;
        while (!lcd_if.lcd_req && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rst_wait_timeout", int'(n < 500), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_req", int'(lcd_if.lcd_req), 0);
        check("mid_rst_row", int'(lcd_if.lcd_row), 0);
        check("mid_rst_col", int'(lcd_if.lcd_col), 0);
        check("mid_rst_char", int'(lcd_if.lcd_char), 0);
        check("mid_rst_change", int'(change_req), 0);
        check("mid_rst_id", int'(next_ui_id), 0);
        check("mid_rst_cursor", int'(cursor_idx), 0);
        exp_q.delete();
        chg_q.delete();
        m_cur = 0; m_top = 0; nw_cur = 0; m_id = 4'h0;
        rst = 1'b0;
        push_frame(0);
        wait_quiet();
        check("post_rst_cursor", int'(cursor_idx), 0);
        check("post_rst_id", int'(next_ui_id), 0);

        check("exp_left", exp_q.size(), 0);
        check("chg_left", chg_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
